// File: rtl/axil_tt_pkg.sv
// Shared definitions for the AXI-Lite times-table block.
// Holds the register byte offsets, the response codes and the FSM state type.
package axil_tt_pkg;

    localparam logic [4:0] REG_A      = 5'h00;
    localparam logic [4:0] REG_B      = 5'h04;
    localparam logic [4:0] REG_CTRL   = 5'h08;
    localparam logic [4:0] REG_RESULT = 5'h0C;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } tt_state_t;

endpackage

// File: rtl/shift_add_mul.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle, OP_W cycles total.
// product only updates when a full multiply completes, so it always holds the last finished result.
module shift_add_mul #(
    parameter int OP_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [OP_W-1:0]     a,
    input  logic [OP_W-1:0]     b,
    output logic                busy,
    output logic                last,
    output logic [2*OP_W-1:0]   product
);
    localparam int RES_W = 2 * OP_W;
    localparam int CNT_W = $clog2(OP_W + 1);

    logic [RES_W-1:0] a_sh_reg;
    logic [RES_W-1:0] acc_reg;
    logic [RES_W-1:0] acc_next;
    logic [RES_W-1:0] product_reg;
    logic [OP_W-1:0]  b_sh_reg;
    logic [CNT_W-1:0] cnt_reg;

    assign acc_next = b_sh_reg[0] ? acc_reg + a_sh_reg : acc_reg;
    assign busy     = (cnt_reg != '0);
    assign last     = (cnt_reg == CNT_W'(1));
    assign product  = product_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            a_sh_reg    <= '0;
            acc_reg     <= '0;
            product_reg <= '0;
            b_sh_reg    <= '0;
            cnt_reg     <= '0;
        end else if (start) begin
            a_sh_reg <= RES_W'(a);
            b_sh_reg <= b;
            acc_reg  <= '0;
            cnt_reg  <= CNT_W'(OP_W);
        end else if (busy) begin
            acc_reg  <= acc_next;
            a_sh_reg <= a_sh_reg << 1;
            b_sh_reg <= b_sh_reg >> 1;
            cnt_reg  <= cnt_reg - CNT_W'(1);
            if (last) begin
                product_reg <= acc_next;
            end
        end
    end

endmodule

// File: rtl/axil_times_table.sv
// AXI-Lite slave computing A*B on a CTRL start; result readable at RESULT.
// Define AXIL_TT_FAST_MUL_EN for a single-cycle combinational multiply (start goes straight to DONE).
module axil_times_table
    import axil_tt_pkg::*;
#(
    parameter int OP_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  awaddr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready,
    input  logic [4:0]  araddr,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready
);
    localparam int RES_W = 2 * OP_W;

    tt_state_t        state_reg;
    logic [OP_W-1:0]  a_reg;
    logic [OP_W-1:0]  b_reg;
    logic [RES_W-1:0] product;
    logic             awready_reg;
    logic             bvalid_reg;
    logic [1:0]       bresp_reg;
    logic             arready_reg;
    logic             rvalid_reg;
    logic [1:0]       rresp_reg;
    logic [31:0]      rdata_reg;

    logic [4:0]  wr_off;
    logic [4:0]  rd_off;
    logic        wr_fire;
    logic        rd_fire;
    logic        wr_ok;
    logic        wr_start;
    logic        start_fire;
    logic        calc_end;
    logic [1:0]  bresp_next;
    logic [31:0] rdata_next;
    logic [1:0]  rresp_next;
    logic        unused_bits;

    assign unused_bits = &{1'b0, wdata[31:OP_W], awaddr[1:0], araddr[1:0]};

    assign wr_off     = {awaddr[4:2], 2'b00};
    assign rd_off     = {araddr[4:2], 2'b00};
    assign wr_fire    = awready_reg && awvalid && wvalid;
    assign rd_fire    = arready_reg && arvalid;
    assign start_fire = wr_fire && wr_start;

`ifdef AXIL_TT_FAST_MUL_EN
    localparam tt_state_t RUN_STATE = DONE;
    logic [RES_W-1:0] product_reg;

    assign calc_end = 1'b1;
    assign product  = product_reg;

    // Operands are stable registers here, so the product is captured on the start edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            product_reg <= '0;
        end else if (start_fire) begin
            product_reg <= RES_W'(a_reg) * RES_W'(b_reg);
        end
    end
`else
    localparam tt_state_t RUN_STATE = CALC;
    logic mul_busy;
    logic mul_last;

    assign calc_end = mul_last || !mul_busy;

    shift_add_mul #(
        .OP_W(OP_W)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (start_fire),
        .a       (a_reg),
        .b       (b_reg),
        .busy    (mul_busy),
        .last    (mul_last),
        .product (product)
    );
`endif

    always_comb begin
        wr_ok    = 1'b0;
        wr_start = 1'b0;
        case (wr_off)
            REG_A, REG_B: wr_ok = (state_reg != CALC);
            REG_CTRL: begin
                wr_ok    = (state_reg != CALC);
                wr_start = wr_ok && wdata[0];
            end
            default: wr_ok = 1'b0;
        endcase
        bresp_next = wr_ok ? RESP_OKAY : RESP_SLVERR;
    end

    always_comb begin
        rdata_next = '0;
        rresp_next = RESP_OKAY;
        case (rd_off)
            REG_A:      rdata_next[OP_W-1:0]  = a_reg;
            REG_B:      rdata_next[OP_W-1:0]  = b_reg;
            REG_CTRL:   rdata_next[1:0]       = {state_reg == CALC, state_reg == DONE};
            REG_RESULT: rdata_next[RES_W-1:0] = product;
            default:    rresp_next            = RESP_SLVERR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg   <= IDLE;
            a_reg       <= '0;
            b_reg       <= '0;
            awready_reg <= 1'b0;
            bvalid_reg  <= 1'b0;
            bresp_reg   <= RESP_OKAY;
            arready_reg <= 1'b0;
            rvalid_reg  <= 1'b0;
            rresp_reg   <= RESP_OKAY;
            rdata_reg   <= '0;
        end else begin
            // Single-cycle ready pulse; the !awready term stops a second accept of the same beat.
            awready_reg <= awvalid && wvalid && !bvalid_reg && !awready_reg;

            if (wr_fire) begin
                bvalid_reg <= 1'b1;
                bresp_reg  <= bresp_next;
                if (wr_ok && wr_off == REG_A) a_reg <= wdata[OP_W-1:0];
                if (wr_ok && wr_off == REG_B) b_reg <= wdata[OP_W-1:0];
            end else if (bvalid_reg && bready) begin
                bvalid_reg <= 1'b0;
            end

            if (rd_fire) begin
                rvalid_reg  <= 1'b1;
                arready_reg <= 1'b0;
                rdata_reg   <= rdata_next;
                rresp_reg   <= rresp_next;
            end else if (rvalid_reg && rready) begin
                rvalid_reg  <= 1'b0;
                arready_reg <= 1'b1;
            end else if (!rvalid_reg) begin
                arready_reg <= 1'b1;
            end

            // A start in DONE takes priority over the RESULT read that would return to IDLE.
            case (state_reg)
                IDLE: if (start_fire) state_reg <= RUN_STATE;
                CALC: if (calc_end) state_reg <= DONE;
                DONE: begin
                    if (start_fire) begin
                        state_reg <= RUN_STATE;
                    end else if (rd_fire && rd_off == REG_RESULT) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign awready = awready_reg;
    assign wready  = awready_reg;
    assign bvalid  = bvalid_reg;
    assign bresp   = bresp_reg;
    assign arready = arready_reg;
    assign rvalid  = rvalid_reg;
    assign rdata   = rdata_reg;
    assign rresp   = rresp_reg;

endmodule

// File: tb/tb_axil_times_table.sv
// Directed bench for axil_times_table (OP_W=8); honours AXIL_TT_FAST_MUL_EN for timing expectations.
module tb_axil_times_table;
    import axil_tt_pkg::*;

    localparam int OP_W = 8;
`ifdef AXIL_TT_FAST_MUL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [4:0]  araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int last_wr_cyc = 0;
    int last_rd_cyc = 0;

    axil_times_table #(.OP_W(OP_W)) dut (
        .clk(clk), .rst(rst),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = 0x%0h", tag, got);
        end
    endtask

    // All bus tasks are entered and left at a falling edge.
    task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, output logic [1:0] resp);
        int n;
        awaddr = addr; wdata = data; awvalid = 1'b1; wvalid = 1'b1;
        n = 0;
        while (!(awready && wready) && n < 20) begin @(negedge clk); n++; end
        if (!(awready && wready)) check_eq("aw_timeout", {31'b0, awready}, 32'h1);
        last_wr_cyc = cyc;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 20) begin @(negedge clk); n++; end
        if (!bvalid) check_eq("b_timeout", {31'b0, bvalid}, 32'h1);
        resp = bresp;
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        $display("[TB] write 0x%02h <= 0x%08h resp %0d", addr, data, resp);
    endtask

    task automatic axi_read(input logic [4:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int n;
        araddr = addr; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 20) begin @(negedge clk); n++; end
        if (!arready) check_eq("ar_timeout", {31'b0, arready}, 32'h1);
        last_rd_cyc = cyc;
        @(negedge clk);
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 20) begin @(negedge clk); n++; end
        if (!rvalid) check_eq("r_timeout", {31'b0, rvalid}, 32'h1);
        data = rdata; resp = rresp;
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        $display("[TB] read  0x%02h => 0x%08h resp %0d", addr, data, resp);
    endtask

    task automatic poll_done(input string tag);
        logic [31:0] d;
        logic [1:0]  r;
        int n;
        d = '0;
        n = 0;
        while (n < 40) begin
            axi_read(REG_CTRL, d, r);
            if (d[0]) break;
            n++;
        end
        check_eq(tag, d, 32'h1);
    endtask

    initial begin
        logic [31:0] d, d2, d0;
        logic [1:0]  r, r2, r0;
        bit          stable, saw_ready;
        int          target, n;

        rst = 1'b0; awaddr = '0; awvalid = 1'b0; wdata = '0; wvalid = 1'b0;
        bready = 1'b0; araddr = '0; arvalid = 1'b0; rready = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_handshake", {23'b0, awready, wready, bvalid, arready, rvalid, bresp, rresp}, 32'h0);
        check_eq("rst_rdata", rdata, 32'h0);
        rst = 1'b1;
        @(negedge clk);

        axi_read(REG_CTRL, d, r);   check_eq("ctrl_after_rst", d, 32'h0);
        axi_read(REG_RESULT, d, r); check_eq("result_after_rst", d, 32'h0);

        // 3 x 7 with polling
        axi_write(REG_A, 32'h3, r);  check_eq("wr_a_resp", r, RESP_OKAY);
        axi_write(REG_B, 32'h7, r);  check_eq("wr_b_resp", r, RESP_OKAY);
        axi_read(REG_A, d, r);       check_eq("rd_a", d, 32'h3);
        axi_write(REG_CTRL, 32'h1, r); check_eq("start_resp", r, RESP_OKAY);
        poll_done("done_3x7");
        axi_read(REG_RESULT, d, r);  check_eq("result_3x7", d, 32'd21);
        check_eq("result_3x7_resp", r, RESP_OKAY);
        axi_read(REG_CTRL, d, r);    check_eq("ctrl_cleared", d, 32'h0);

        axi_write(REG_CTRL, 32'h0, r); check_eq("ctrl_nostart_resp", r, RESP_OKAY);
        axi_read(REG_CTRL, d, r);      check_eq("ctrl_nostart", d, 32'h0);

        // 255 x 255 and done latency
        axi_write(REG_A, 32'hFF, r);
        axi_write(REG_B, 32'hFF, r);
        axi_write(REG_CTRL, 32'h1, r);
`ifndef AXIL_TT_FAST_MUL_EN
        target = last_wr_cyc;
        axi_read(REG_RESULT, d, r);  check_eq("result_in_calc", d, 32'd21);
        while (cyc < target + OP_W) @(negedge clk);
        axi_read(REG_CTRL, d, r);    check_eq("ctrl_before_done", d, 32'h2);
`endif
        poll_done("done_255");
        axi_read(REG_RESULT, d, r);  check_eq("result_255", d, 32'd65025);
        axi_write(REG_CTRL, 32'h1, r);
        target = last_wr_cyc + (FAST ? 1 : OP_W + 1);
        while (cyc < target) @(negedge clk);
        axi_read(REG_CTRL, d, r);    check_eq("ctrl_first_done", d, 32'h1);
        if (!FAST) check_eq("first_done_cycle", last_rd_cyc, target);
        axi_read(REG_RESULT, d, r);  check_eq("result_255_again", d, 32'd65025);

        // operand write while busy
        axi_write(REG_A, 32'd12, r);
        axi_write(REG_B, 32'd10, r);
        axi_write(REG_CTRL, 32'h1, r);
        axi_write(REG_A, 32'd5, r);  check_eq("wr_a_busy_resp", r, FAST ? RESP_OKAY : RESP_SLVERR);
        poll_done("done_12x10");
        axi_read(REG_RESULT, d, r);  check_eq("result_12x10", d, 32'd120);
        axi_read(REG_A, d, r);       check_eq("a_after_busy_wr", d, FAST ? 32'd5 : 32'd12);

        // unmapped and read-only accesses
        axi_read(5'h14, d, r);       check_eq("rd_unmapped_data", d, 32'h0);
        check_eq("rd_unmapped_resp", r, RESP_SLVERR);
        axi_write(REG_RESULT, 32'hFFFF, r); check_eq("wr_result_resp", r, RESP_SLVERR);
        axi_write(5'h10, 32'h1, r);  check_eq("wr_unmapped_resp", r, RESP_SLVERR);
        axi_read(REG_RESULT, d, r);  check_eq("result_unchanged", d, 32'd120);

        // start and RESULT read accepted in the same DONE cycle
        axi_write(REG_A, 32'd2, r);
        axi_write(REG_B, 32'd3, r);
        axi_write(REG_CTRL, 32'h1, r);
        poll_done("done_2x3");
        axi_write(REG_A, 32'd4, r);  check_eq("wr_a_in_done_resp", r, RESP_OKAY);
        fork
            axi_write(REG_CTRL, 32'h1, r2);
            begin
                @(negedge clk);
                axi_read(REG_RESULT, d2, r0);
            end
        join
        check_eq("same_cycle", last_rd_cyc, last_wr_cyc);
        check_eq("race_old_result", d2, 32'd6);
        check_eq("race_start_resp", r2, RESP_OKAY);
        axi_read(REG_CTRL, d, r);    check_eq("race_start_wins", d, FAST ? 32'h1 : 32'h2);
        poll_done("done_4x3");
        axi_read(REG_RESULT, d, r);  check_eq("result_4x3", d, 32'd12);

        // write response held off by bready, with a second write pending
        awaddr = REG_B; wdata = 32'h22; awvalid = 1'b1; wvalid = 1'b1;
        n = 0;
        while (!awready && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        r0 = bresp; stable = bvalid; saw_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (!bvalid || bresp !== r0) stable = 1'b0;
            if (awready) saw_ready = 1'b1;
        end
        check_eq("b_hold", {30'b0, stable, saw_ready}, 32'h2);
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        n = 0;
        while (!awready && n < 20) begin @(negedge clk); n++; end
        check_eq("aw_after_release", {31'b0, awready}, 32'h1);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        axi_read(REG_B, d, r);       check_eq("rd_b_after_hold", d, 32'h22);

        // read data held off by rready
        araddr = REG_B; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        arvalid = 1'b0;
        d0 = rdata; stable = rvalid;
        repeat (5) begin
            @(negedge clk);
            if (!rvalid || rdata !== d0 || rresp !== RESP_OKAY) stable = 1'b0;
        end
        check_eq("r_hold", {31'b0, stable}, 32'h1);
        check_eq("r_hold_data", d0, 32'h22);
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;

        // reset in the middle of a calculation
        axi_write(REG_A, 32'd9, r);
        axi_write(REG_B, 32'd9, r);
        axi_write(REG_CTRL, 32'h1, r);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("midrst_handshake", {27'b0, awready, wready, bvalid, arready, rvalid}, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        axi_read(REG_CTRL, d, r);    check_eq("midrst_ctrl", d, 32'h0);
        axi_read(REG_RESULT, d, r);  check_eq("midrst_result", d, 32'h0);
        axi_read(REG_A, d, r);       check_eq("midrst_a", d, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axil_times_table.md
AXIL_TIMES_TABLE -- requirements
Module: axil_times_table

Interface
REQ-001 SHALL have parameter OP_W, default 8, operand width in bits (legal range 2..16).
REQ-002 SHALL derive localparam RES_W = 2*OP_W, the result width.
REQ-003 SHALL have ports:
 clk  in  1  single clock, all logic on rising edge
 rst  in  1  synchronous, active-low reset
 awaddr  in  5  write address (byte)
 awvalid/awready  in/out  1  write-address handshake
 wdata  in  32  write data
 wvalid/wready  in/out  1  write-data handshake
 bresp  out  2  write response (00 OKAY, 10 SLVERR)
 bvalid/bready  out/in  1  write-response handshake
 araddr  in  5  read address (byte)
 arvalid/arready  in/out  1  read-address handshake
 rdata  out  32  read data
 rresp  out  2  read response
 rvalid/rready  out/in  1  read-data handshake

Function
REQ-004 Register map: 0x00 A (RW, OP_W LSBs); 0x04 B (RW, OP_W LSBs); 0x08 CTRL (write bit0=1 starts; read {30'b0, busy, done}); 0x0C RESULT (RO, RES_W LSBs, zero-extended).
REQ-005 Write: awready and wready SHALL pulse together for one cycle only when awvalid, wvalid and !bvalid; bvalid asserts the next cycle and holds until bready.
REQ-006 Read: arready SHALL be high when !rvalid; rvalid asserts the cycle after acceptance, rdata/rresp stable until rready.
REQ-007 Writes to RESULT, unmapped addresses (0x10-0x1F), or A/B/CTRL while busy SHALL be ignored with bresp=SLVERR.
REQ-008 Reads of unmapped addresses SHALL return rdata=0, rresp=SLVERR; all others OKAY.
REQ-009 FSM states IDLE, CALC, DONE; start accepted in IDLE or DONE moves to CALC and clears done.
REQ-010 CALC SHALL run shift-add for exactly OP_W cycles, then enter DONE; start handshake at cycle N gives done=1 readable from cycle N+OP_W+1.
REQ-011 busy=1 exactly in CALC; done=1 exactly in DONE.
REQ-012 A RESULT read accepted in DONE SHALL return the product and move FSM to IDLE (done clears); RESULT read in IDLE/CALC returns last completed product.
REQ-013 Product SHALL be exact unsigned A*B in RES_W bits; no overflow possible.
REQ-014 CTRL write with bit0=0 SHALL be OKAY and have no effect.
REQ-015 Simultaneous write-start and RESULT read in DONE: read returns old product, start wins, FSM to CALC.

Reset
REQ-016 When rst=0 at a clk edge: A, B, RESULT=0; FSM=IDLE; all ready/valid outputs=0; bresp, rresp, rdata=0.
REQ-017 Reset mid-CALC or mid-handshake SHALL abort without producing a response; first transaction after rst=1 behaves as from power-up.

Configuration
REQ-018 Macro AXIL_TT_FAST_MUL_EN: when defined, multiply is single-cycle combinational, start goes directly to DONE and done=1 from cycle N+1; when undefined, iterative per REQ-010. Register map and handshakes identical in both.

Structure
REQ-019 Package axil_tt_pkg SHALL hold register offsets, RESP_OKAY/RESP_SLVERR constants and the FSM state typedef.
REQ-020 Iterative datapath SHALL be sub-module shift_add_mul (start, operands in; busy, product out), omitted when AXIL_TT_FAST_MUL_EN is defined.

Verification
REQ-021 A=3, B=7, start, poll CTRL until done, read RESULT -> 21, OKAY, done then 0.
REQ-022 A=255, B=255 (OP_W=8) -> RESULT 65025; done first seen exactly 9 cycles after start handshake (1 with macro).
REQ-023 start, then write A=5 while busy -> bresp SLVERR; RESULT equals product of original operands.
REQ-024 Hold bready=0 for 5 cycles after write -> bvalid and bresp stable, no further awready; hold rready=0 -> rdata stable.
REQ-025 Read 0x14 -> rdata 0, SLVERR; write 0x0C -> SLVERR, RESULT unchanged.
REQ-026 Assert rst=0 mid-CALC -> next cycle busy=0, done=0, RESULT=0, all valids 0.
